ysyx_23060096_muldiv: RTL and testbench
=======================================

YSYX_23060096_MULDIV -- requirements
Module: ysyx_23060096_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset; synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, the operation request.
REQ-005 The block SHALL have port in_ready, output, 1, high when a new operation can be accepted.
REQ-006 The block SHALL have port op, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have port busA, input, DATA_WIDTH, rs1 operand from the register file.
REQ-008 The block SHALL have port busB, input, DATA_WIDTH, rs2 operand from the register file.
REQ-009 The block SHALL have port out_valid, output, 1, high when result holds a completed value.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepting the result.
REQ-011 The block SHALL have port result, output, DATA_WIDTH, the operation result.

Function
REQ-012 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-014 An accept SHALL occur on an edge with in_valid and in_ready both high; op, busA and busB SHALL be latched on that edge and ignored otherwise.
REQ-015 On a normal accept, the state SHALL go IDLE->BUSY, and a 5-bit iteration counter SHALL be cleared to 0.
REQ-016 BUSY SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; after the 32nd step the state SHALL go to DONE, so out_valid rises exactly 32 edges after the accept edge.
REQ-017 Signed operands SHALL be converted to magnitude at accept; the final sign SHALL be applied on entry to DONE.
REQ-018 The product sign SHALL be the XOR of the operand signs (MULHSU treats busB as unsigned).
REQ-019 The quotient sign SHALL be the XOR of the operand signs, and the remainder sign SHALL follow the dividend.
REQ-020 MUL SHALL return the low 32 bits of the 64-bit product; MULH, MULHSU and MULHU SHALL return the high 32 bits.
REQ-021 Divide-by-zero (busB==0) SHALL go IDLE->DONE directly on the accept edge (1-cycle latency).
REQ-022 For DIV/DIVU by zero, result SHALL be 32'hFFFFFFFF; for REM/REMU by zero, result SHALL be busA.
REQ-023 Signed overflow (DIV/REM with busA=32'h80000000, busB=32'hFFFFFFFF) SHALL go IDLE->DONE directly, with DIV result 32'h80000000 and REM result 0.
REQ-024 In DONE, result and out_valid SHALL hold stable until out_ready is high; DONE&out_ready SHALL go to IDLE.
REQ-025 There SHALL be no same-cycle accept in DONE: in_ready is low in DONE.
REQ-026 in_valid and out_ready SHALL be ignored while BUSY.
REQ-027 result SHALL be 0 whenever the state is not DONE.

Reset
REQ-028 With rstn low at an edge, the state SHALL become IDLE, and counter, operand registers and accumulators SHALL become 0, regardless of the current state.
REQ-029 During reset, outputs SHALL be: in_ready=1 after the reset edge, out_valid=0, result=0.
REQ-030 Reset mid-BUSY or mid-DONE SHALL discard the operation without producing any out_valid pulse.

Configuration
REQ-031 With the macro YSYX_23060096_FAST_MUL_EN defined, the four multiply ops SHALL compute in one cycle (accept edge IDLE->DONE, 64-bit combinational product).
REQ-032 Without YSYX_23060096_FAST_MUL_EN, multiply ops SHALL use the iterative 32-cycle BUSY path; divide behaviour SHALL be identical in both builds.

Verification
REQ-033 Scenario: MUL busA=7, busB=-3 (32'hFFFFFFFD) -> result 32'hFFFFFFEB; out_valid 32 cycles after accept (1 cycle with FAST_MUL_EN).
REQ-034 Scenario: MULH 32'h80000000 x 32'h80000000 -> 32'h40000000; MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE; MULHSU 32'hFFFFFFFF x 2 -> 32'hFFFFFFFF.
REQ-035 Scenario: DIV -7/2 -> 32'hFFFFFFFD and REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14 and REMU 100/7 -> 2; each with 32-cycle latency.
REQ-036 Scenario: DIVU 5/0 -> 32'hFFFFFFFF and REM 5/0 -> 5, both out_valid on the cycle after accept; DIV 32'h80000000/-1 -> 32'h80000000.
REQ-037 Scenario: hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout; then out_ready=1 -> IDLE next edge with in_ready=1.
REQ-038 Scenario: assert rstn=0 at BUSY cycle 15 -> next edge in IDLE with out_valid=0 and result=0; a new DIVU 9/3 then returns 3 normally.

Source files
------------

// File: rtl/ysyx_23060096_muldiv.sv
// RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes.
// Define YSYX_23060096_FAST_MUL_EN to compute the four multiply ops in a single cycle.
module ysyx_23060096_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] busA,
  input  logic [DATA_WIDTH-1:0] busB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONES_W = {W{1'b1}};
  localparam logic [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg_d(input logic [2*W-1:0] x);
    return ~x + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r;
  logic [4:0]       cnt_r;
  logic [2:0]       op_r;
  logic             neg_r;
  logic [W-1:0]     b_r;
  logic [2*W-1:0]   acc_r;
  logic [W-1:0]     result_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             a_signed_s;
  logic             b_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic             res_neg_s;
  logic [W-1:0]     a_mag_s;
  logic [W-1:0]     b_mag_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic             direct_s;
  logic [W-1:0]     direct_res_s;

  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_next_s;
  logic [W:0]       rem_sh_s;
  logic [W:0]       rem_diff_s;
  logic [2*W-1:0]   div_next_s;
  logic [2*W-1:0]   step_s;
  logic [2*W-1:0]   prod_s;
  logic [W-1:0]     quot_s;
  logic [W-1:0]     rem_s;
  logic [W-1:0]     final_s;

  // Operand signedness per funct3; MUL low half is sign-agnostic so it runs unsigned.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op)
      OP_MUL:    begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      OP_MULHU:  begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      OP_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_DIVU:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_REMU:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
  end

  // Accept-time magnitudes, result sign and the early-exit cases.
  always_comb begin
    a_neg_s   = a_signed_s & busA[W-1];
    b_neg_s   = b_signed_s & busB[W-1];
    a_mag_s   = a_neg_s ? neg_w(busA) : busA;
    b_mag_s   = b_neg_s ? neg_w(busB) : busB;
    // The remainder follows the dividend; every other result takes the XOR of the signs.
    if (op == OP_REM) begin
      res_neg_s = a_neg_s;
    end else begin
      res_neg_s = a_neg_s ^ b_neg_s;
    end
    div_zero_s = op[2] & (busB == ZERO_W);
    div_ovf_s  = op[2] & ~op[0] & (busA == MIN_W) & (busB == ONES_W);
    if (div_zero_s) begin
      direct_res_s = op[1] ? busA : ONES_W;
    end else if (div_ovf_s) begin
      direct_res_s = op[1] ? ZERO_W : MIN_W;
    end else begin
      direct_res_s = ZERO_W;
    end
    direct_s = div_zero_s | div_ovf_s;
  end

`ifdef YSYX_23060096_FAST_MUL_EN
  logic [2*W-1:0] fast_prod_s;
  logic [2*W-1:0] fast_signed_s;
  logic [W-1:0]   fast_res_s;

  // Single-cycle multiply on magnitudes, selected in place of the early-exit value.
  always_comb begin
    fast_prod_s   = {{W{1'b0}}, a_mag_s} * {{W{1'b0}}, b_mag_s};
    fast_signed_s = res_neg_s ? neg_d(fast_prod_s) : fast_prod_s;
    if (op == OP_MUL) begin
      fast_res_s = fast_signed_s[W-1:0];
    end else begin
      fast_res_s = fast_signed_s[2*W-1:W];
    end
  end

  logic           take_direct_s;
  logic [W-1:0]   take_res_s;

  // Multiplies join the direct IDLE->DONE path.
  always_comb begin
    if (!op[2]) begin
      take_direct_s = 1'b1;
      take_res_s    = fast_res_s;
    end else begin
      take_direct_s = direct_s;
      take_res_s    = direct_res_s;
    end
  end
`else
  logic           take_direct_s;
  logic [W-1:0]   take_res_s;

  // Only the divide corner cases bypass the iterative path.
  always_comb begin
    take_direct_s = direct_s;
    take_res_s    = direct_res_s;
  end
`endif

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[W-1:1]};
    rem_sh_s   = {acc_r[2*W-1:W], acc_r[W-1]};
    rem_diff_s = rem_sh_s - {1'b0, b_r};
    if (rem_sh_s >= {1'b0, b_r}) begin
      div_next_s = {rem_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[W-1:0], acc_r[W-2:0], 1'b0};
    end
    step_s = op_r[2] ? div_next_s : mul_next_s;
  end

  // Sign fix-up applied to the value produced by the final iteration.
  always_comb begin
    prod_s = neg_r ? neg_d(step_s) : step_s;
    quot_s = neg_r ? neg_w(step_s[W-1:0]) : step_s[W-1:0];
    rem_s  = neg_r ? neg_w(step_s[2*W-1:W]) : step_s[2*W-1:W];
    if (op_r[2]) begin
      final_s = op_r[1] ? rem_s : quot_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_s = prod_s[W-1:0];
    end else begin
      final_s = prod_s[2*W-1:W];
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      op_r        <= 3'd0;
      neg_r       <= 1'b0;
      b_r         <= ZERO_W;
      acc_r       <= {(2*W){1'b0}};
      result_r    <= ZERO_W;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r       <= op;
            neg_r      <= res_neg_s;
            cnt_r      <= 5'd0;
            b_r        <= b_mag_s;
            acc_r      <= {ZERO_W, a_mag_s};
            in_ready_r <= 1'b0;
            if (take_direct_s) begin
              state_r     <= DONE;
              result_r    <= take_res_s;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r     <= DONE;
            result_r    <= final_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            result_r    <= ZERO_W;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          result_r    <= ZERO_W;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_ysyx_23060096_muldiv.sv
// Directed table-driven bench for ysyx_23060096_muldiv, plus hold and mid-operation reset sequences.
module tb_ysyx_23060096_muldiv;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef YSYX_23060096_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  ysyx_23060096_muldiv #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .busA      (busA),
    .busB      (busB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Accept one op, then wait (bounded) for out_valid while driving ignored noise.
  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat_exp, output int edges);
    @(negedge clk);
    op = o; busA = a; busB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); busA = $urandom; busB = $urandom;
    edges = 0;
    if (lat_exp != 0) check({nm, "_busy_result_zero"}, {32'd0, result}, 64'd0);
    while (!out_valid && edges < 100) begin
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      edges++;
    end
  endtask

  task automatic retire(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_retire_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({nm, "_retire_result"}, {32'd0, result}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    issue(v.nm, v.op, v.a, v.b, v.lat, edges);
    check({v.nm, "_result"}, {32'd0, result}, {32'd0, v.exp});
    check({v.nm, "_latency"}, 64'(edges), 64'(v.lat));
    check({v.nm, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
    retire(v.nm);
  endtask

  initial begin
    int edges;
    int seen;

    vecs[0]  = '{"mul_7_m3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{"mul_shift",      3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT};
    vecs[2]  = '{"mulh_min_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[3]  = '{"mulh_m1_m1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[4]  = '{"mulhsu_m1_2",    3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT};
    vecs[5]  = '{"mulhu_max_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[6]  = '{"mulhu_2p16",     3'b011, 32'h00010000, 32'h00010000, 32'h00000001, MUL_LAT};
    vecs[7]  = '{"div_m7_2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT};
    vecs[8]  = '{"rem_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT};
    vecs[9]  = '{"div_7_m2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
    vecs[10] = '{"rem_7_m2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT};
    vecs[11] = '{"divu_100_7",     3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT};
    vecs[12] = '{"remu_100_7",     3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT};
    vecs[13] = '{"divu_big_3",     3'b101, 32'h80000000, 32'd3,        32'h2AAAAAAA, DIV_LAT};
    vecs[14] = '{"remu_big_3",     3'b111, 32'h80000000, 32'd3,        32'd2,        DIV_LAT};
    vecs[15] = '{"divu_max_1",     3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT};
    vecs[16] = '{"divu_5_0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[17] = '{"rem_5_0",        3'b110, 32'd5,        32'd0,        32'd5,        0};
    vecs[18] = '{"div_ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[19] = '{"rem_ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; busA = 32'd0; busB = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i]);
    end

    // Hold DONE for 10 cycles with a competing request that must not be taken.
    issue("hold", 3'b101, 32'd100, 32'd7, DIV_LAT, edges);
    check("hold_latency", 64'(edges), 64'(DIV_LAT));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b000; busA = 32'd3; busB = 32'd3;
      @(posedge clk); #1;
      check("hold_result", {32'd0, result}, 64'd14);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    retire("hold");

    // Reset during BUSY cycle 15 discards the operation.
    @(negedge clk);
    op = 3'b100; busA = 32'd1000; busB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_result", {32'd0, result}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midreset_no_pulse", 64'(seen), 64'd0);
    issue("after_reset", 3'b101, 32'd9, 32'd3, DIV_LAT, edges);
    check("after_reset_result", {32'd0, result}, 64'd3);
    check("after_reset_latency", 64'(edges), 64'(DIV_LAT));
    retire("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
